// File: rtl/fifo_burst_reader_if.sv
// Bus bundle between the burst reader, its source FIFO and the DDR3
// write-command/data port. The reader takes the master modport; whatever
// models or implements the FIFO and the DDR3 side takes the slave modport.
interface fifo_burst_reader_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_rd_en;
  logic                  fifo_empty;
  logic                  fifo_almost_empty;
  logic                  bst_req;
  logic                  bst_ack;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_valid;
  logic                  wr_ready;
  logic                  wr_last;

  modport master (
    input  fifo_rd_data, fifo_empty, fifo_almost_empty, bst_ack, wr_ready,
    output fifo_rd_en, bst_req, wr_data, wr_valid, wr_last
  );

  modport slave (
    output fifo_rd_data, fifo_empty, fifo_almost_empty, bst_ack, wr_ready,
    input  fifo_rd_en, bst_req, wr_data, wr_valid, wr_last
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains a registered-output FIFO in fixed BURST_LEN
// bursts. A req/ack command is raised first, then the words are streamed
// out on a valid/ready/last interface through a 2-entry skid buffer that
// hides the FIFO's one-cycle read latency and downstream backpressure.
// Optional build macro FIFO_BURST_STAT_EN adds burst_cnt / stall_cnt.
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 8,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  fifo_burst_reader_if.master     bus,
`ifdef FIFO_BURST_STAT_EN
  output logic [15:0]             burst_cnt,
  output logic [15:0]             stall_cnt,
`endif
  output logic                    busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] BURST_LEN_C = CNT_WIDTH'(BURST_LEN);
  localparam logic [CNT_WIDTH-1:0] LAST_BEAT_C = CNT_WIDTH'(BURST_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] ONE_C       = CNT_WIDTH'(1);

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            occ_q, occ_d;
  logic [DATA_WIDTH-1:0] skid0_q, skid0_d;
  logic [DATA_WIDTH-1:0] skid1_q, skid1_d;

  logic                  out_valid;
  logic                  out_last;
  logic                  pop;
  logic                  push;
  logic                  rd_issue;
  logic [2:0]            committed;

  // Output-side view of the skid buffer head and the read issue decision.
  // committed counts words held after this edge's pop, so a read may be
  // issued in the same cycle a word leaves; this keeps 1 beat/clk while
  // never holding more than two words between buffer and FIFO pipeline.
  always_comb begin
    out_valid = (occ_q != 2'd0);
    out_last  = out_valid && (beat_cnt_q == LAST_BEAT_C);
    pop       = out_valid && bus.wr_ready;
    push      = inflight_q;
    committed = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    rd_issue  = (state_q == DATA) && (rd_cnt_q < BURST_LEN_C) &&
                !bus.fifo_empty && (committed < 3'd2);
  end

  // Next-state logic: burst FSM, counters and skid buffer movement.
  always_comb begin
    state_d    = state_q;
    rd_cnt_d   = rd_cnt_q;
    beat_cnt_d = beat_cnt_q;
    inflight_d = rd_issue;
    occ_d      = occ_q;
    skid0_d    = skid0_q;
    skid1_d    = skid1_q;

    unique case (state_q)
      IDLE: begin
        if (!bus.fifo_almost_empty) state_d = REQ;
      end
      REQ: begin
        if (bus.bst_ack) begin
          state_d    = DATA;
          rd_cnt_d   = '0;
          beat_cnt_d = '0;
        end
      end
      DATA: begin
        if (rd_issue) rd_cnt_d = rd_cnt_q + ONE_C;
        if (pop) begin
          beat_cnt_d = beat_cnt_q + ONE_C;
          if (out_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Word arriving from the FIFO joins behind whatever is still queued.
    unique case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) skid0_d = bus.fifo_rd_data;
        else               skid1_d = bus.fifo_rd_data;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        skid0_d = skid1_q;
        occ_d   = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          skid0_d = bus.fifo_rd_data;
        end else begin
          skid0_d = skid1_q;
          skid1_d = bus.fifo_rd_data;
        end
      end
      default: ;
    endcase
  end

  // State register; reset aborts any burst in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_cnt_q   <= '0;
      beat_cnt_q <= '0;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      skid0_q    <= '0;
      skid1_q    <= '0;
    end else begin
      state_q    <= state_d;
      rd_cnt_q   <= rd_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      skid0_q    <= skid0_d;
      skid1_q    <= skid1_d;
    end
  end

  assign bus.fifo_rd_en = rd_issue;
  assign bus.bst_req    = (state_q == REQ);
  assign bus.wr_valid   = out_valid;
  assign bus.wr_last    = out_last;
  assign bus.wr_data    = out_valid ? skid0_q : '0;
  assign busy           = (state_q != IDLE);

`ifdef FIFO_BURST_STAT_EN
  logic [15:0] burst_cnt_q, burst_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Statistics: completed bursts (wrapping) and backpressured cycles (saturating).
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (pop && out_last) burst_cnt_d = burst_cnt_q + 16'd1;
    if ((state_q == DATA) && out_valid && !bus.wr_ready && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_cnt_q <= 16'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign burst_cnt = burst_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule
